// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: pixel-clock VGA timing generator that drains a non-showahead
// pixel FIFO, blanks to black on underflow and drives the DAC/connector pins.
// The counter stage (stage 0) and the pins are two registers apart for both pixel and control.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] iRED,
  input  logic [9:0] iGREEN,
  input  logic [9:0] iBLUE,
  input  logic       iEMPTY,
  input  logic       iCLR_UFLOW,
  output logic       oREQ,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oSOF,
  output logic       oUNDERFLOW
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region bounds compared at 11 bits so a 1024-long line does not alias to 0.
  localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS_W  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE_W  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_W = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS_W  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE_W  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

  // stage 0: scan counters
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       act, hs_raw, vs_raw, sof_raw, uflow_set;

  // stage 1: timing delayed one cycle, plus the read marker for the FIFO q
  logic       req1_q, act1_q, hs1_q, vs1_q, sof1_q;
  logic [9:0] x1_q, y1_q;

  // stage 2: pin registers
  logic [9:0] r_q, g_q, b_q, x_q, y_q;
  logic       hs_q, vs_q, bn_q, sof_q, uflow_q;

  // Next scan position; wrap at the end of the frame is seamless.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  // Stage-0 decode of regions, read request and underflow detection.
  always_comb begin
    act       = ({1'b0, h_q} < H_ACT_W) && ({1'b0, v_q} < V_ACT_W);
    hs_raw    = !(({1'b0, h_q} >= H_SS_W) && ({1'b0, h_q} < H_SE_W));
    vs_raw    = !(({1'b0, v_q} >= V_SS_W) && ({1'b0, v_q} < V_SE_W));
    sof_raw   = (h_q == 10'd0) && (v_q == 10'd0);
    oREQ      = act && !iEMPTY && !RESET;
    uflow_set = act && iEMPTY && !RESET;
  end

  // Scan counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage 1: delay timing so it lines up with the FIFO q arriving next cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      req1_q <= 1'b0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      sof1_q <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
    end else begin
      req1_q <= oREQ;
      act1_q <= act;
      hs1_q  <= hs_raw;
      vs1_q  <= vs_raw;
      sof1_q <= sof_raw;
      x1_q   <= act ? h_q : 10'd0;
      y1_q   <= act ? v_q : 10'd0;
    end
  end

  // Stage 2: pins; a pixel without a read (blank or underflow) goes out black.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      bn_q  <= 1'b0;
      sof_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      r_q   <= req1_q ? iRED   : 10'd0;
      g_q   <= req1_q ? iGREEN : 10'd0;
      b_q   <= req1_q ? iBLUE  : 10'd0;
      hs_q  <= hs1_q;
      vs_q  <= vs1_q;
      bn_q  <= act1_q;
      sof_q <= sof1_q;
      x_q   <= x1_q;
      y_q   <= y1_q;
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RESET)           uflow_q <= 1'b0;
    else if (uflow_set)  uflow_q <= 1'b1;
    else if (iCLR_UFLOW) uflow_q <= 1'b0;
  end

  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = bn_q;
  assign oVGA_SYNC_N  = 1'b0;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oSOF         = sof_q;
  assign oUNDERFLOW   = uflow_q;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: default horizontal timing, a short 19-line frame
// (12 active, 2 FP, 2 sync, 3 BP) so that several frames fit in the run.
module tb_vga_scan_ctrl;
  localparam int HT = 800;
  localparam int FR = HT * 19;

  logic       CLK = 1'b0;
  logic       RESET, iEMPTY, iCLR_UFLOW, oREQ;
  logic [9:0] iRED, iGREEN, iBLUE, oVGA_R, oVGA_G, oVGA_B, oX, oY;
  logic       oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oSOF, oUNDERFLOW;

  int checks = 0;
  int errors = 0;
  int edges  = 0;   // edges since RESET last sampled high = stage-0 position
  int rh, rv;
  logic uf_en = 1'b0;
  logic [9:0] q_r = '0, q_g = '0, q_b = '0;

  vga_scan_ctrl #(.V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut (
    .CLK(CLK), .RESET(RESET), .iRED(iRED), .iGREEN(iGREEN), .iBLUE(iBLUE),
    .iEMPTY(iEMPTY), .iCLR_UFLOW(iCLR_UFLOW), .oREQ(oREQ),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
    .oVGA_SYNC_N(oVGA_SYNC_N), .oX(oX), .oY(oY), .oSOF(oSOF), .oUNDERFLOW(oUNDERFLOW));

  always #5 CLK = ~CLK;

  // Pixel content the FIFO holds for position (x,y).
  function automatic logic [9:0] pat_r(int x, int y);
    logic [9:0] xv, yv;
    xv = 10'(x); yv = 10'(y);
    if (x == 5 && y == 3) return 10'h155;
    return {yv[4:0], xv[4:0]};
  endfunction

  always @(posedge CLK) edges <= RESET ? 0 : edges + 1;

  always_comb begin
    rh = (edges % FR) % HT;
    rv = (edges % FR) / HT;
  end

  assign iEMPTY = uf_en && (rh == 100) && (rv == 10);

  // Non-showahead FIFO: q for the pixel read is valid the cycle after oREQ.
  always @(posedge CLK) if (oREQ) begin
    q_r <= pat_r(rh, rv);
    q_g <= 10'(rh);
    q_b <= 10'h200 | 10'(rv);
  end
  assign iRED = q_r;
  assign iGREEN = q_g;
  assign iBLUE = q_b;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  task automatic goto_edges(int t);
    int guard = 0;
    @(negedge CLK);
    while (edges != t) begin
      @(negedge CLK);
      guard++;
      if (guard > 100000) begin
        $display("FAIL goto_timeout actual=%0d expected=%0d", edges, t);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
      end
    end
  endtask

  // Pixel number n (counted from the last reset release) is on the pins.
  task automatic goto_pix(int n);
    goto_edges(n + 2);
  endtask

  typedef struct {
    int h, v;
    logic hs, vs, bn, sof;
    logic [9:0] x, y, r, g, b;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(int h, int v, logic hs, logic vs, logic bn, logic sof,
                              logic [9:0] x, logic [9:0] y, logic [9:0] r, logic [9:0] g, logic [9:0] b);
    vec_t t;
    t.h = h; t.v = v; t.hs = hs; t.vs = vs; t.bn = bn; t.sof = sof;
    t.x = x; t.y = y; t.r = r; t.g = g; t.b = b;
    return t;
  endfunction

  initial begin
    int n_req, n_bn, n_vs, n_hs0, n_sof, n_dirty, vs_first, bn_fall, hs_fall;
    //          h    v  hs vs bn sof  x     y    r       g       b
    tbl[0]  = mk(1,   0, 1, 1, 1, 0, 1,   0,  10'h001, 10'd1,   10'h200);
    tbl[1]  = mk(5,   3, 1, 1, 1, 0, 5,   3,  10'h155, 10'd5,   10'h203);
    tbl[2]  = mk(639, 3, 1, 1, 1, 0, 639, 3,  10'h07F, 10'h27F, 10'h203);
    tbl[3]  = mk(640, 3, 1, 1, 0, 0, 0,   0,  0, 0, 0);
    tbl[4]  = mk(655, 3, 1, 1, 0, 0, 0,   0,  0, 0, 0);
    tbl[5]  = mk(656, 3, 0, 1, 0, 0, 0,   0,  0, 0, 0);
    tbl[6]  = mk(751, 3, 0, 1, 0, 0, 0,   0,  0, 0, 0);
    tbl[7]  = mk(752, 3, 1, 1, 0, 0, 0,   0,  0, 0, 0);
    tbl[8]  = mk(0,  11, 1, 1, 1, 0, 0,  11,  10'h160, 10'd0,   10'h20B);
    tbl[9]  = mk(0,  12, 1, 1, 0, 0, 0,   0,  0, 0, 0);
    tbl[10] = mk(0,  14, 1, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[11] = mk(700,15, 0, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[12] = mk(0,  16, 1, 1, 0, 0, 0,   0,  0, 0, 0);
    tbl[13] = mk(799,18, 1, 1, 0, 0, 0,   0,  0, 0, 0);
    tbl[14] = mk(0,  19, 1, 1, 1, 1, 0,   0,  10'h000, 10'd0,   10'h200);

    RESET = 1'b1; iCLR_UFLOW = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    uf_en = 1'b1;

    // Mid-frame reset after an underflow has been latched.
    goto_pix(10 * HT + 105);
    chk("uflow_before_reset", oUNDERFLOW, 1);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_r", oVGA_R, 0); chk("rst_g", oVGA_G, 0); chk("rst_b", oVGA_B, 0);
    chk("rst_hs", oVGA_HS, 1); chk("rst_vs", oVGA_VS, 1); chk("rst_bn", oVGA_BLANK_N, 0);
    chk("rst_x", oX, 0); chk("rst_y", oY, 0); chk("rst_sof", oSOF, 0);
    chk("rst_uflow", oUNDERFLOW, 0); chk("rst_req", oREQ, 0); chk("sync_n", oVGA_SYNC_N, 0);
    RESET = 1'b0;
    uf_en = 1'b0;
    goto_edges(1);
    chk("sof_early", oSOF, 0);
    goto_edges(2);
    chk("sof_first", oSOF, 1); chk("sof_bn", oVGA_BLANK_N, 1);
    chk("sof_x", oX, 0); chk("sof_y", oY, 0);

    // Directed pin vectors through the first frame and into the next.
    foreach (tbl[i]) begin
      goto_pix(tbl[i].v * HT + tbl[i].h);
      chk($sformatf("hs@%0d,%0d", tbl[i].h, tbl[i].v), oVGA_HS, tbl[i].hs);
      chk($sformatf("vs@%0d,%0d", tbl[i].h, tbl[i].v), oVGA_VS, tbl[i].vs);
      chk($sformatf("bn@%0d,%0d", tbl[i].h, tbl[i].v), oVGA_BLANK_N, tbl[i].bn);
      chk($sformatf("sof@%0d,%0d", tbl[i].h, tbl[i].v), oSOF, tbl[i].sof);
      chk($sformatf("x@%0d,%0d", tbl[i].h, tbl[i].v), oX, tbl[i].x);
      chk($sformatf("y@%0d,%0d", tbl[i].h, tbl[i].v), oY, tbl[i].y);
      chk($sformatf("r@%0d,%0d", tbl[i].h, tbl[i].v), oVGA_R, tbl[i].r);
      chk($sformatf("g@%0d,%0d", tbl[i].h, tbl[i].v), oVGA_G, tbl[i].g);
      chk($sformatf("b@%0d,%0d", tbl[i].h, tbl[i].v), oVGA_B, tbl[i].b);
    end
    chk("uflow_clean", oUNDERFLOW, 0);

    // Whole-frame line/frame timing, starting on the second frame's SOF.
    n_req = 0; n_bn = 0; n_vs = 0; n_hs0 = 0; n_sof = 0; n_dirty = 0;
    vs_first = -1; bn_fall = -1; hs_fall = -1;
    for (int i = 0; i < FR; i++) begin
      if (oREQ) n_req++;
      if (oVGA_BLANK_N) n_bn++;
      if (oSOF) n_sof++;
      if (!oVGA_VS) begin n_vs++; if (vs_first < 0) vs_first = i; end
      if (!oVGA_BLANK_N && (oVGA_R != 0 || oVGA_G != 0 || oVGA_B != 0)) n_dirty++;
      if (i < HT) begin
        if (!oVGA_HS) begin n_hs0++; if (hs_fall < 0) hs_fall = i; end
        if (!oVGA_BLANK_N && bn_fall < 0) bn_fall = i;
      end
      @(negedge CLK);
    end
    chk("frame_req", n_req, 640 * 12);
    chk("frame_bn_high", n_bn, 640 * 12);
    chk("frame_sof_count", n_sof, 1);
    chk("sof_period", oSOF, 1);
    chk("vs_low_cycles", n_vs, 1600);
    chk("vs_start", vs_first, 14 * HT);
    chk("blank_rgb_zero", n_dirty, 0);
    chk("line_bn_high", bn_fall, 640);
    chk("hs_fall_offset", hs_fall - bn_fall, 16);
    chk("hs_low_cycles", n_hs0, 96);

    // Underflow at (100,10) of the third frame.
    uf_en = 1'b1;
    goto_edges(2 * FR + 10 * HT + 100);
    chk("uf_req", oREQ, 0);
    chk("uf_flag_pre", oUNDERFLOW, 0);
    goto_pix(2 * FR + 10 * HT + 99);
    chk("uf_prev_r", oVGA_R, 10'h143); chk("uf_prev_g", oVGA_G, 10'd99);
    goto_pix(2 * FR + 10 * HT + 100);
    chk("uf_r", oVGA_R, 0); chk("uf_g", oVGA_G, 0); chk("uf_b", oVGA_B, 0);
    chk("uf_bn", oVGA_BLANK_N, 1); chk("uf_x", oX, 100); chk("uf_y", oY, 10);
    goto_pix(2 * FR + 10 * HT + 101);
    chk("uf_next_r", oVGA_R, 10'h145); chk("uf_next_g", oVGA_G, 10'd101);
    chk("uf_next_b", oVGA_B, 10'h20A); chk("uf_flag", oUNDERFLOW, 1);
    goto_pix(2 * FR + 12 * HT);
    chk("uf_sticky", oUNDERFLOW, 1);
    iCLR_UFLOW = 1'b1;
    @(negedge CLK);
    iCLR_UFLOW = 1'b0;
    chk("uf_cleared", oUNDERFLOW, 0);

    // Clear in the same cycle as a fresh underflow: set wins.
    goto_edges(3 * FR + 10 * HT + 100);
    chk("coll_pre", oUNDERFLOW, 0);
    iCLR_UFLOW = 1'b1;
    @(negedge CLK);
    iCLR_UFLOW = 1'b0;
    chk("coll_set_wins", oUNDERFLOW, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
